// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the CSR access unit.
//   - CSR address map constants (user counters, machine counters, machine CSRs)
//   - Zicsr funct3 encodings
//   - FSM state encoding
//   - cnt_wr_sel encodings for the counter write port
package csr_pkg;

    // Read-only user counter views
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // Writable machine CSRs owned by this unit
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;

    // Machine counter aliases, only mapped when counter writes are enabled
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [2:0] {
        F3_RW  = 3'b001,
        F3_RS  = 3'b010,
        F3_RC  = 3'b011,
        F3_RWI = 3'b101,
        F3_RSI = 3'b110,
        F3_RCI = 3'b111
    } csr_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } csr_state_e;

    localparam logic [1:0] CNT_SEL_CYCLE_LO   = 2'b00;
    localparam logic [1:0] CNT_SEL_CYCLE_HI   = 2'b01;
    localparam logic [1:0] CNT_SEL_INSTRET_LO = 2'b10;
    localparam logic [1:0] CNT_SEL_INSTRET_HI = 2'b11;

    // funct3 000 and 100 are not Zicsr operations; every legal op has a
    // non-zero low pair (01 write, 10 set, 11 clear).
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return f3[1:0] != 2'b00;
    endfunction

    // RW/RWI always write; the set/clear forms only write with a non-zero source.
    function automatic logic f3_write_intent(input logic [2:0] f3, input logic src_is_x0);
        return (f3[1:0] == 2'b01) || !src_is_x0;
    endfunction

endpackage

// File: rtl/csr_access_unit_alu.sv
// csr_alu: combinational Zicsr new-value computation.
// Ports:
//   old_val  in  32  current CSR value
//   src      in  32  rs1 value or zero-extended uimm
//   funct3   in  3   Zicsr funct3
//   new_val  out 32  value the CSR would take after the operation
// Unmasked: field masking (mtvec/mepc alignment) is applied by the caller.
module csr_alu
    import csr_pkg::*;
(
    input  logic [31:0] old_val,
    input  logic [31:0] src,
    input  logic [2:0]  funct3,
    output logic [31:0] new_val
);

    always_comb begin
        new_val = old_val;
        case (funct3)
            F3_RW, F3_RWI: new_val = src;
            F3_RS, F3_RSI: new_val = old_val | src;
            F3_RC, F3_RCI: new_val = old_val & ~src;
            default:       new_val = old_val;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit: Zicsr read-modify-write executor beside EX.
// One request at a time: IDLE -> ACCESS -> RESP -> IDLE.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid is not withdrawn by the producer before the transfer
// (flush excepted), and the payload is held stable while valid is high.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     kills any in-flight request (any state)
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_funct3/addr/src/src_is_x0  request payload, latched on acceptance
//   resp_valid/resp_ready     response handshake (valid only in RESP)
//   resp_rdata/resp_illegal   old CSR value (0 if illegal) and illegal flag
//   cycle_*/instret_*         counter values from the counter block
//   cnt_wr_en/sel/data        single-cycle counter write pulse during ACCESS
// Configuration: CSR_COUNTER_WRITE_EN maps mcycle/mcycleh/minstret/minstreth
// as read/write and drives the counter write port; otherwise those addresses
// are illegal and the counter write port is tied to zero.
module csr_access_unit
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_src,
    input  logic        req_src_is_x0,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_illegal,
    input  logic [31:0] cycle_low,
    input  logic [31:0] cycle_high,
    input  logic [31:0] instret_low,
    input  logic [31:0] instret_high,
    output logic        cnt_wr_en,
    output logic [1:0]  cnt_wr_sel,
    output logic [31:0] cnt_wr_data
);

    csr_state_e  state;

    logic [2:0]  lat_funct3;
    logic [11:0] lat_addr;
    logic [31:0] lat_src;
    logic        lat_src_is_x0;

    logic [31:0] mscratch;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    logic [31:0] old_val;
    logic [31:0] alu_val;
    logic [31:0] new_val;
    logic [31:0] wr_mask;
    logic        mapped;
    logic        read_only;
    logic        write_intent;
    logic        illegal;
    logic        commit;

`ifdef CSR_COUNTER_WRITE_EN
    logic        is_cnt;
    logic [1:0]  cnt_sel;
`endif

    // Address decode of the latched request; counter reads see the inputs
    // present during ACCESS.
    always_comb begin
        old_val   = 32'h0;
        mapped    = 1'b0;
        read_only = 1'b0;
        wr_mask   = 32'hFFFF_FFFF;
`ifdef CSR_COUNTER_WRITE_EN
        is_cnt    = 1'b0;
        cnt_sel   = CNT_SEL_CYCLE_LO;
`endif
        case (lat_addr)
            CSR_CYCLE:     begin old_val = cycle_low;    mapped = 1'b1; read_only = 1'b1; end
            CSR_CYCLEH:    begin old_val = cycle_high;   mapped = 1'b1; read_only = 1'b1; end
            CSR_INSTRET:   begin old_val = instret_low;  mapped = 1'b1; read_only = 1'b1; end
            CSR_INSTRETH:  begin old_val = instret_high; mapped = 1'b1; read_only = 1'b1; end
            CSR_MSCRATCH:  begin old_val = mscratch;     mapped = 1'b1; end
            // Direct-mode trap vector and aligned EPC: low two bits never stored.
            CSR_MTVEC:     begin old_val = mtvec;        mapped = 1'b1; wr_mask = 32'hFFFF_FFFC; end
            CSR_MEPC:      begin old_val = mepc;         mapped = 1'b1; wr_mask = 32'hFFFF_FFFC; end
`ifdef CSR_COUNTER_WRITE_EN
            CSR_MCYCLE:    begin old_val = cycle_low;    mapped = 1'b1; is_cnt = 1'b1; cnt_sel = CNT_SEL_CYCLE_LO;   end
            CSR_MCYCLEH:   begin old_val = cycle_high;   mapped = 1'b1; is_cnt = 1'b1; cnt_sel = CNT_SEL_CYCLE_HI;   end
            CSR_MINSTRET:  begin old_val = instret_low;  mapped = 1'b1; is_cnt = 1'b1; cnt_sel = CNT_SEL_INSTRET_LO; end
            CSR_MINSTRETH: begin old_val = instret_high; mapped = 1'b1; is_cnt = 1'b1; cnt_sel = CNT_SEL_INSTRET_HI; end
`endif
            default: ;
        endcase
    end

    csr_alu u_alu (
        .old_val (old_val),
        .src     (lat_src),
        .funct3  (lat_funct3),
        .new_val (alu_val)
    );

    assign new_val      = alu_val & wr_mask;
    assign write_intent = f3_write_intent(lat_funct3, lat_src_is_x0);
    assign illegal      = !mapped || !f3_is_legal(lat_funct3) || (write_intent && read_only);
    // A write leaves ACCESS only when nothing kills it.
    assign commit       = (state == ST_ACCESS) && !flush && !illegal && write_intent;

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

`ifdef CSR_COUNTER_WRITE_EN
    assign cnt_wr_en   = commit && is_cnt;
    assign cnt_wr_sel  = cnt_wr_en ? cnt_sel : 2'b00;
    assign cnt_wr_data = cnt_wr_en ? new_val : 32'h0;
`else
    assign cnt_wr_en   = 1'b0;
    assign cnt_wr_sel  = 2'b00;
    assign cnt_wr_data = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            lat_funct3    <= 3'b000;
            lat_addr      <= 12'h000;
            lat_src       <= 32'h0;
            lat_src_is_x0 <= 1'b0;
            mscratch      <= 32'h0;
            mtvec         <= 32'h0;
            mepc          <= 32'h0;
            resp_rdata    <= 32'h0;
            resp_illegal  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Flush beats a simultaneous request.
                    if (!flush && req_valid) begin
                        lat_funct3    <= req_funct3;
                        lat_addr      <= req_addr;
                        lat_src       <= req_src;
                        lat_src_is_x0 <= req_src_is_x0;
                        state         <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        if (commit) begin
                            case (lat_addr)
                                CSR_MSCRATCH: mscratch <= new_val;
                                CSR_MTVEC:    mtvec    <= new_val;
                                CSR_MEPC:     mepc     <= new_val;
                                default: ;
                            endcase
                        end
                        resp_rdata   <= illegal ? 32'h0 : old_val;
                        resp_illegal <= illegal;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (flush || resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: directed requests, a CSR-map model, a per-cycle
// compare process and literal checks of the expected read-back values.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'b000;
    logic [11:0] req_addr = 12'h000;
    logic [31:0] req_src = 32'h0;
    logic        req_src_is_x0 = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic [31:0] cycle_low = 32'h0;
    logic [31:0] cycle_high = 32'h0;
    logic [31:0] instret_low = 32'h0;
    logic [31:0] instret_high = 32'h0;
    logic        cnt_wr_en;
    logic [1:0]  cnt_wr_sel;
    logic [31:0] cnt_wr_data;

    csr_access_unit dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_src       (req_src),
        .req_src_is_x0 (req_src_is_x0),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_illegal  (resp_illegal),
        .cycle_low     (cycle_low),
        .cycle_high    (cycle_high),
        .instret_low   (instret_low),
        .instret_high  (instret_high),
        .cnt_wr_en     (cnt_wr_en),
        .cnt_wr_sel    (cnt_wr_sel),
        .cnt_wr_data   (cnt_wr_data)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on = 1'b0;

    logic        exp_ready = 1'b1;
    logic        exp_resp_valid = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_illegal = 1'b0;
    logic        exp_cnt_en = 1'b0;
    logic [1:0]  exp_cnt_sel = 2'b00;
    logic [31:0] exp_cnt_data = 32'h0;

    // Writable CSR contents as the bench believes them to be.
    logic [31:0] csr_q [logic [11:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One compare process: every cycle after reset, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && cmp_on) begin
            chk("req_ready",   {31'b0, req_ready},  {31'b0, exp_ready});
            chk("resp_valid",  {31'b0, resp_valid}, {31'b0, exp_resp_valid});
            if (exp_resp_valid) begin
                chk("resp_rdata",   resp_rdata,              exp_rdata);
                chk("resp_illegal", {31'b0, resp_illegal},   {31'b0, exp_illegal});
            end
            chk("cnt_wr_en",   {31'b0, cnt_wr_en},  {31'b0, exp_cnt_en});
            chk("cnt_wr_sel",  {30'b0, cnt_wr_sel}, {30'b0, exp_cnt_sel});
            chk("cnt_wr_data", cnt_wr_data,         exp_cnt_data);
        end
    end

    // ---------------- model ----------------
    // Outcome of a request evaluated against the address map and Zicsr rules.
    task automatic model_eval(input logic [2:0] f3, input logic [11:0] a,
                              input logic [31:0] s, input logic x0,
                              output logic [31:0] rd, output logic ill,
                              output logic wen, output logic cnt,
                              output logic [1:0] sel, output logic [31:0] wdata);
        logic [31:0] old;
        logic        is_map;
        logic        is_ro;
        logic        op_ok;
        logic        wants_write;
        logic [31:0] nv;
        old = 32'h0; is_map = 1'b0; is_ro = 1'b0; cnt = 1'b0; sel = 2'b00;
        if (a == 12'hC00) begin old = cycle_low;    is_map = 1; is_ro = 1; end
        if (a == 12'hC80) begin old = cycle_high;   is_map = 1; is_ro = 1; end
        if (a == 12'hC02) begin old = instret_low;  is_map = 1; is_ro = 1; end
        if (a == 12'hC82) begin old = instret_high; is_map = 1; is_ro = 1; end
        if (csr_q.exists(a)) begin old = csr_q[a]; is_map = 1; end
`ifdef CSR_COUNTER_WRITE_EN
        if (a == 12'hB00) begin old = cycle_low;    is_map = 1; cnt = 1; sel = 2'd0; end
        if (a == 12'hB80) begin old = cycle_high;   is_map = 1; cnt = 1; sel = 2'd1; end
        if (a == 12'hB02) begin old = instret_low;  is_map = 1; cnt = 1; sel = 2'd2; end
        if (a == 12'hB82) begin old = instret_high; is_map = 1; cnt = 1; sel = 2'd3; end
`endif
        op_ok = !(f3 == 3'd0 || f3 == 3'd4);
        wants_write = (f3 == 3'd1 || f3 == 3'd5) ? 1'b1 : !x0;
        if (f3 == 3'd1 || f3 == 3'd5)      nv = s;
        else if (f3 == 3'd2 || f3 == 3'd6) nv = old | s;
        else                               nv = old & ~s;
        if (a == 12'h305 || a == 12'h341) nv = {nv[31:2], 2'b00};
        ill   = !is_map || !op_ok || (wants_write && is_ro);
        rd    = ill ? 32'h0 : old;
        wen   = !ill && wants_write;
        cnt   = cnt && wen;
        sel   = cnt ? sel : 2'b00;
        wdata = nv;
    endtask

    // ---------------- driver ----------------
    // Issues one request with hand-timed expectations. hold = extra RESP cycles
    // with resp_ready low; flush_access / flush_resp kill it in that state.
    task automatic run_req(input logic [2:0] f3, input logic [11:0] a,
                           input logic [31:0] s, input logic x0,
                           input int hold, input bit flush_access, input bit flush_resp,
                           output logic [31:0] got_rdata, output logic got_ill);
        logic [31:0] m_rd;
        logic        m_ill;
        logic        m_wen;
        logic        m_cnt;
        logic [1:0]  m_sel;
        logic [31:0] m_wd;
        got_rdata = 32'hX;
        got_ill   = 1'bX;
        // IDLE: present the request
        req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_src = s; req_src_is_x0 = x0;
        exp_ready = 1'b1; exp_resp_valid = 1'b0; exp_cnt_en = 1'b0;
        exp_cnt_sel = 2'b00; exp_cnt_data = 32'h0;
        @(posedge clk); #1;
        // ACCESS
        req_valid = 1'b0; req_funct3 = 3'b000; req_addr = 12'hFFF; req_src = 32'h0;
        model_eval(f3, a, s, x0, m_rd, m_ill, m_wen, m_cnt, m_sel, m_wd);
        exp_ready = 1'b0;
        if (flush_access) begin
            flush = 1'b1;
        end else begin
            exp_cnt_en   = m_cnt;
            exp_cnt_sel  = m_cnt ? m_sel : 2'b00;
            exp_cnt_data = m_cnt ? m_wd : 32'h0;
        end
        @(posedge clk); #1;
        flush = 1'b0;
        exp_cnt_en = 1'b0; exp_cnt_sel = 2'b00; exp_cnt_data = 32'h0;
        if (flush_access) begin
            exp_ready = 1'b1;
            got_rdata = 32'h0;
            got_ill   = 1'b0;
            return;
        end
        if (m_wen && csr_q.exists(a)) csr_q[a] = m_wd;
        // RESP
        exp_resp_valid = 1'b1; exp_rdata = m_rd; exp_illegal = m_ill;
        @(negedge clk);
        got_rdata = resp_rdata;
        got_ill   = resp_illegal;
        if (flush_resp) begin
            #1 flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end else begin
            repeat (hold) @(posedge clk);
            #1 resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
        end
        exp_resp_valid = 1'b0;
        exp_ready = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic        il;
        csr_q[12'h340] = 32'h0;
        csr_q[12'h305] = 32'h0;
        csr_q[12'h341] = 32'h0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_req_ready",  {31'b0, req_ready},    32'd1);
        chk("reset_resp_valid", {31'b0, resp_valid},   32'd0);
        chk("reset_rdata",      resp_rdata,            32'd0);
        chk("reset_illegal",    {31'b0, resp_illegal}, 32'd0);
        chk("reset_cnt_en",     {31'b0, cnt_wr_en},    32'd0);
        cmp_on = 1'b1;
        @(posedge clk); #1;

        // mscratch write then set-with-x0 read
        run_req(3'b001, 12'h340, 32'hDEADBEEF, 1'b0, 0, 0, 0, rd, il);
        chk("lit_rw_mscratch_old", rd, 32'h0);
        run_req(3'b010, 12'h340, 32'h0, 1'b1, 0, 0, 0, rd, il);
        chk("lit_rs_x0_mscratch", rd, 32'hDEADBEEF);
        run_req(3'b010, 12'h340, 32'h0, 1'b1, 1, 0, 0, rd, il);
        chk("lit_rs_x0_no_write", rd, 32'hDEADBEEF);

        // mtvec / mepc alignment masking
        run_req(3'b001, 12'h305, 32'h12345677, 1'b0, 0, 0, 0, rd, il);
        run_req(3'b010, 12'h305, 32'h0, 1'b1, 0, 0, 0, rd, il);
        chk("lit_mtvec_masked", rd, 32'h12345674);
        run_req(3'b001, 12'h341, 32'h0000000F, 1'b0, 0, 0, 0, rd, il);
        run_req(3'b010, 12'h341, 32'h0, 1'b1, 0, 0, 0, rd, il);
        chk("lit_mepc_masked", rd, 32'h0000000C);

        // read-only counters
        cycle_low = 32'h100; cycle_high = 32'h2;
        instret_low = 32'h55; instret_high = 32'h9;
        run_req(3'b010, 12'hC00, 32'h0, 1'b1, 0, 0, 0, rd, il);
        chk("lit_cycle", rd, 32'h100);
        run_req(3'b010, 12'hC80, 32'h0, 1'b1, 0, 0, 0, rd, il);
        chk("lit_cycleh", rd, 32'h2);
        run_req(3'b001, 12'hC00, 32'h5, 1'b0, 0, 0, 0, rd, il);
        chk("lit_rw_ro_illegal", {31'b0, il}, 32'd1);
        chk("lit_rw_ro_rdata", rd, 32'h0);
        run_req(3'b110, 12'hC02, 32'h1, 1'b0, 0, 0, 0, rd, il);
        chk("lit_rsi_ro_illegal", {31'b0, il}, 32'd1);
        run_req(3'b011, 12'hC82, 32'h0, 1'b1, 0, 0, 0, rd, il);
        chk("lit_instreth", rd, 32'h9);

        // bad funct3 and unmapped address
        run_req(3'b000, 12'h340, 32'h1, 1'b0, 0, 0, 0, rd, il);
        chk("lit_f3_000_illegal", {31'b0, il}, 32'd1);
        run_req(3'b100, 12'h340, 32'h1, 1'b0, 0, 0, 0, rd, il);
        chk("lit_f3_100_illegal", {31'b0, il}, 32'd1);
        run_req(3'b010, 12'h123, 32'h0, 1'b1, 0, 0, 0, rd, il);
        chk("lit_unmapped_illegal", {31'b0, il}, 32'd1);

        // immediate forms on mscratch
        run_req(3'b110, 12'h340, 32'h10, 1'b0, 0, 0, 0, rd, il);
        chk("lit_rsi_old", rd, 32'hDEADBEEF);
        run_req(3'b111, 12'h340, 32'hF, 1'b0, 0, 0, 0, rd, il);
        chk("lit_rci_old", rd, 32'hDEADBEFF);
        run_req(3'b101, 12'h340, 32'h0, 1'b1, 0, 0, 0, rd, il);
        chk("lit_rwi_old", rd, 32'hDEADBEF0);
        run_req(3'b011, 12'h340, 32'h0, 1'b1, 0, 0, 0, rd, il);
        chk("lit_rwi_x0_wrote", rd, 32'h0);

        // back-pressure: five cycles with resp_ready low
        run_req(3'b001, 12'h340, 32'h1234, 1'b0, 5, 0, 0, rd, il);
        run_req(3'b010, 12'h340, 32'h0, 1'b1, 5, 0, 0, rd, il);
        chk("lit_backpressure", rd, 32'h1234);

        // flush during ACCESS: no write, no response
        run_req(3'b001, 12'h340, 32'h55, 1'b0, 0, 1, 0, rd, il);
        run_req(3'b010, 12'h340, 32'h0, 1'b1, 0, 0, 0, rd, il);
        chk("lit_flush_access_nowrite", rd, 32'h1234);

        // flush in IDLE beats req_valid
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h340; req_src = 32'h77;
        req_src_is_x0 = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        run_req(3'b010, 12'h340, 32'h0, 1'b1, 0, 0, 0, rd, il);
        chk("lit_flush_idle_noaccept", rd, 32'h1234);

        // flush in RESP: response dropped, write already committed
        run_req(3'b001, 12'h340, 32'hAA, 1'b0, 0, 0, 1, rd, il);
        @(posedge clk); #1;
        run_req(3'b010, 12'h340, 32'h0, 1'b1, 0, 0, 0, rd, il);
        chk("lit_flush_resp_committed", rd, 32'hAA);

        // machine counter write port
        run_req(3'b001, 12'hB82, 32'h7, 1'b0, 0, 0, 0, rd, il);
`ifdef CSR_COUNTER_WRITE_EN
        chk("lit_minstreth_legal", {31'b0, il}, 32'd0);
        chk("lit_minstreth_old", rd, 32'h9);
`else
        chk("lit_minstreth_illegal", {31'b0, il}, 32'd1);
        chk("lit_minstreth_rdata", rd, 32'h0);
`endif
        run_req(3'b010, 12'hB00, 32'h0, 1'b1, 0, 0, 0, rd, il);
`ifdef CSR_COUNTER_WRITE_EN
        chk("lit_mcycle_read", rd, 32'h100);
`else
        chk("lit_mcycle_illegal", {31'b0, il}, 32'd1);
`endif

        repeat (2) @(posedge clk);
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
